axis_pkt_sink: RTL and testbench
================================

AXIS_PKT_SINK -- requirements
Module: axis_pkt_sink

Interface
REQ-001 Parameter DW, default 16: stream data width in bits.
REQ-002 Parameter AW, default 12: address width of the upstream FIFO; the length field is AW+1 bits.
REQ-003 Parameter MAXLEN, default 2048: maximum legal packet length in beats; must not exceed 2^AW.
REQ-004 clk  in  1: the single clock; all logic is on its rising edge.
REQ-005 rst  in  1: synchronous, active-high reset.
REQ-006 s_tdata  in  DW: slave AXI-Stream data.
REQ-007 s_tvalid  in  1: slave beat valid.
REQ-008 s_tlast  in  1: marks the last beat of a packet.
REQ-009 s_tready  out  1: sink accepts a beat.
REQ-010 bp_mode  in  2: backpressure mode; 0 = always, 1 = alternate, 2 = LFSR, 3 = hold.
REQ-011 st_len  out  AW+1: length of the reported packet in beats.
REQ-012 st_sum  out  DW: sum of the reported packet's data, mod 2^DW.
REQ-013 st_err  out  1: the reported packet exceeded MAXLEN.
REQ-014 st_valid  out  1: the report is valid.
REQ-015 st_ready  in  1: the report consumer accepts the report.
REQ-016 pkt_cnt  out  32: number of completed packets since reset, wrapping.
REQ-017 beat_cnt  out  32: number of accepted beats since reset, wrapping.

Function
REQ-018 A beat SHALL be accepted only in a cycle where s_tvalid && s_tready is sampled high at the clk edge.
REQ-019 The FSM SHALL have two states, RECV and REPORT, with reset state RECV.
REQ-020 In RECV: s_tready = bp_ready and st_valid = 0.
REQ-021 In REPORT: s_tready = 0 and st_valid = 1.
REQ-022 bp_ready by mode:
- mode 0: 1.
- mode 1: a toggle flop that resets to 1 and inverts every cycle.
- mode 2: lfsr[0].
- mode 3: 0.
REQ-023 bp_mode SHALL be sampled combinationally every cycle; a change takes effect in the same cycle without resetting the toggle flop or the LFSR.
REQ-024 The LFSR SHALL be 8-bit Fibonacci with polynomial x^8+x^6+x^5+x^4+1, seeded 8'hA5 on reset, and advance every cycle regardless of mode or state.
REQ-025 On each accepted beat:
- len_acc = min(len_acc+1, MAXLEN);
- sum_acc = (sum_acc + s_tdata) mod 2^DW;
- beat_cnt increments.
REQ-026 An accepted beat while len_acc == MAXLEN SHALL set err_acc; len_acc stays saturated at MAXLEN and the beat is still accepted and summed.
REQ-027 An accepted beat with s_tlast = 1 SHALL, at the same edge:
- latch st_len, st_sum and st_err from the updated accumulators;
- increment pkt_cnt;
- clear len_acc, sum_acc and err_acc;
- enter REPORT.
REQ-028 st_valid SHALL rise the cycle after the tlast beat is accepted (latency 1).
REQ-029 st_len, st_sum and st_err SHALL remain stable while st_valid = 1.
REQ-030 In REPORT, st_valid && st_ready SHALL return the FSM to RECV at that edge; s_tready can be high in the next cycle (one-cycle bubble minimum).
REQ-031 In REPORT, st_valid SHALL hold indefinitely while st_ready = 0; no beats are accepted.
REQ-032 A single-beat packet (s_tlast on the first beat) SHALL report st_len = 1.
REQ-033 pkt_cnt and beat_cnt SHALL wrap from 2^32-1 to 0.

Reset
REQ-034 While rst = 1 at an edge, the block SHALL set:
- state = RECV;
- s_tready = 0 during reset cycles;
- st_valid = 0, st_len = 0, st_sum = 0, st_err = 0;
- pkt_cnt = 0, beat_cnt = 0;
- accumulators = 0, toggle flop = 1, LFSR = 8'hA5.
REQ-035 Reset asserted mid-packet or in REPORT SHALL discard the partial packet or pending report with no report emitted; after reset, s_tready follows REQ-020 from the first cycle with rst = 0.

Verification
REQ-036 Mode 0, st_ready = 1, send 4 beats of 1, 2, 3, 4 with tlast on beat 4 -> one report with st_len = 4, st_sum = 10, st_err = 0; pkt_cnt = 1, beat_cnt = 4.
REQ-037 MAXLEN = 2048, send 2049 beats each 16'h0001 with tlast on the last beat -> st_len = 2048, st_err = 1, st_sum = 2049 mod 65536 = 2049.
REQ-038 Mode 1, s_tvalid held high for 8 beats -> s_tready pattern 1,0,1,0...; each beat is accepted exactly once and beat_cnt = 8 after 16 cycles.
REQ-039 Report stalled with st_ready = 0 for 10 cycles -> st_valid and the report fields stay constant, s_tready = 0, beat_cnt is unchanged; st_ready = 1 -> RECV on the next cycle.
REQ-040 Data 16'hFFFF + 16'h0002 in a 2-beat packet -> st_sum = 16'h0001, demonstrating wrap.
REQ-041 rst pulsed after 3 beats of a 5-beat packet -> no report; counters = 0; a following 2-beat packet reports st_len = 2.

Source files
------------

// File: rtl/axis_pkt_sink.sv
// axis_pkt_sink: AXI-Stream packet sink with programmable backpressure.
// Accumulates length, sum and overflow per packet, then holds a report
// until the consumer takes it. Also counts packets and beats since reset.
module axis_pkt_sink #(
    parameter int DW     = 16,
    parameter int AW     = 12,
    parameter int MAXLEN = 2048
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    input  logic          s_tlast,
    output logic          s_tready,
    input  logic [1:0]    bp_mode,
    output logic [AW:0]   st_len,
    output logic [DW-1:0] st_sum,
    output logic          st_err,
    output logic          st_valid,
    input  logic          st_ready,
    output logic [31:0]   pkt_cnt,
    output logic [31:0]   beat_cnt
);

    typedef enum logic {
        RECV   = 1'b0,
        REPORT = 1'b1
    } state_t;

    localparam logic [AW:0] L_MAXLEN = (AW+1)'(MAXLEN);
    localparam logic [7:0]  L_SEED   = 8'hA5;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_tgl;
    logic [7:0]    r_lfsr;
    logic [AW:0]   r_len_acc;
    logic [DW-1:0] r_sum_acc;
    logic          r_err_acc;

    logic          w_bp_ready;
    logic          w_accept;
    logic          w_len_sat;
    logic [AW:0]   w_len_nxt;
    logic [DW-1:0] w_sum_nxt;
    logic          w_err_nxt;
    logic          w_lfsr_fb;

    // Per-beat accumulator updates; saturate length and flag overflow.
    assign w_len_sat = (r_len_acc == L_MAXLEN);
    assign w_len_nxt = w_len_sat ? r_len_acc : r_len_acc + 1'b1;
    assign w_sum_nxt = r_sum_acc + s_tdata;
    assign w_err_nxt = r_err_acc | w_len_sat;

    // Feedback for x^8+x^6+x^5+x^4+1, shifting toward the MSB.
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // Backpressure select, handshake outputs and next-state decode.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
        w_bp_ready  = 1'b1;
        s_tready    = 1'b0;
        st_valid    = 1'b0;
        w_accept    = 1'b0;
        w_state_nxt = r_state;

        case (bp_mode)
            2'd0:    w_bp_ready = 1'b1;
            2'd1:    w_bp_ready = r_tgl;
            2'd2:    w_bp_ready = r_lfsr[0];
            default: w_bp_ready = 1'b0;
        endcase

        case (r_state)
            RECV: begin
                // Gated by rst so no beat appears accepted while reset is held.
                s_tready = w_bp_ready & ~rst;
                w_accept = s_tready & s_tvalid;
                if (w_accept && s_tlast) begin
                    w_state_nxt = REPORT;
                end
            end
            REPORT: begin
                st_valid = 1'b1;
                if (st_ready) begin
                    w_state_nxt = RECV;
                end
            end
            default: w_state_nxt = RECV;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            r_state <= RECV;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Free-running backpressure sources: toggle flop and LFSR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tgl  <= 1'b1;
            r_lfsr <= L_SEED;
        end else begin
            r_tgl  <= ~r_tgl;
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    // Packet accumulators, report latch and running counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_acc <= '0;
            r_sum_acc <= '0;
            r_err_acc <= 1'b0;
            st_len    <= '0;
            st_sum    <= '0;
            st_err    <= 1'b0;
            pkt_cnt   <= '0;
            beat_cnt  <= '0;
        end else if (w_accept) begin
            beat_cnt <= beat_cnt + 32'd1;
            if (s_tlast) begin
                // Report takes the values including this last beat.
                st_len    <= w_len_nxt;
                st_sum    <= w_sum_nxt;
                st_err    <= w_err_nxt;
                pkt_cnt   <= pkt_cnt + 32'd1;
                r_len_acc <= '0;
                r_sum_acc <= '0;
                r_err_acc <= 1'b0;
            end else begin
                r_len_acc <= w_len_nxt;
                r_sum_acc <= w_sum_nxt;
                r_err_acc <= w_err_nxt;
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_sink.sv
// tb_axis_pkt_sink: directed self-checking bench for axis_pkt_sink.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axis_pkt_sink;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam int MAXLEN = 2048;
    localparam int TMO = 200;

    logic          clk;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic [1:0]    bp_mode;
    logic [AW:0]   st_len;
    logic [DW-1:0] st_sum;
    logic          st_err;
    logic          st_valid;
    logic          st_ready;
    logic [31:0]   pkt_cnt;
    logic [31:0]   beat_cnt;

    int total = 0;
    int bad   = 0;

    axis_pkt_sink #(.DW(DW), .AW(AW), .MAXLEN(MAXLEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .bp_mode  (bp_mode),
        .st_len   (st_len),
        .st_sum   (st_sum),
        .st_err   (st_err),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .pkt_cnt  (pkt_cnt),
        .beat_cnt (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int n;
        n = 0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = l;
        #1;
        while (!s_tready && n < TMO) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= TMO) chk("beat_timeout", 64'(0), 64'(1));
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Wait for a report, check it, then consume it.
    task automatic expect_report(input string tag, input int len, input int sum, input logic err);
        int n;
        n = 0;
        while (!st_valid && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) chk({tag, "_rpt_timeout"}, 64'(0), 64'(1));
        chk({tag, "_len"}, 64'(st_len), 64'(len));
        chk({tag, "_sum"}, 64'(st_sum), 64'(sum));
        chk({tag, "_err"}, 64'(st_err), 64'(err));
        st_ready = 1'b1;
        @(negedge clk);
        st_ready = 1'b0;
        chk({tag, "_released"}, 64'(st_valid), 64'(0));
    endtask

    task automatic pulse_reset();
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        #1;
        chk("rst_tready", 64'(s_tready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        bp_mode  = 2'd0;
        st_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_tready_hold", 64'(s_tready), 64'(0));
        chk("rst_valid", 64'(st_valid), 64'(0));
        chk("rst_len", 64'(st_len), 64'(0));
        chk("rst_sum", 64'(st_sum), 64'(0));
        chk("rst_err", 64'(st_err), 64'(0));
        chk("rst_pkt", 64'(pkt_cnt), 64'(0));
        chk("rst_beat", 64'(beat_cnt), 64'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_tready", 64'(s_tready), 64'(1));

        // Four beats 1..4: len 4, sum 10, report one cycle after tlast.
        send_beat(16'd1, 1'b0);
        send_beat(16'd2, 1'b0);
        send_beat(16'd3, 1'b0);
        chk("pre_last_valid", 64'(st_valid), 64'(0));
        send_beat(16'd4, 1'b1);
        chk("latency_valid", 64'(st_valid), 64'(1));
        expect_report("p4", 4, 10, 1'b0);
        chk("p4_pkt", 64'(pkt_cnt), 64'(1));
        chk("p4_beat", 64'(beat_cnt), 64'(4));

        // Sum wraps: FFFF + 0002 = 0001.
        send_beat(16'hFFFF, 1'b0);
        send_beat(16'h0002, 1'b1);
        expect_report("wrap", 2, 1, 1'b0);

        // Single-beat packet.
        send_beat(16'd7, 1'b1);
        expect_report("single", 1, 7, 1'b0);
        chk("single_pkt", 64'(pkt_cnt), 64'(3));
        chk("single_beat", 64'(beat_cnt), 64'(7));

        // Stalled report: fields, valid and tready frozen for 10 cycles.
        send_beat(16'd5, 1'b0);
        send_beat(16'd6, 1'b0);
        send_beat(16'd7, 1'b1);
        s_tvalid = 1'b1;
        s_tdata  = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 64'(st_valid), 64'(1));
            chk("stall_len", 64'(st_len), 64'(3));
            chk("stall_sum", 64'(st_sum), 64'(18));
            chk("stall_tready", 64'(s_tready), 64'(0));
            chk("stall_beat", 64'(beat_cnt), 64'(10));
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        st_ready = 1'b1;
        @(negedge clk);
        st_ready = 1'b0;
        chk("unstall_valid", 64'(st_valid), 64'(0));
        chk("unstall_tready", 64'(s_tready), 64'(1));
        chk("unstall_pkt", 64'(pkt_cnt), 64'(4));

        // Reset mid-packet: partial packet discarded, counters cleared.
        send_beat(16'd9, 1'b0);
        send_beat(16'd9, 1'b0);
        send_beat(16'd9, 1'b0);
        bp_mode = 2'd1;
        pulse_reset();
        chk("midrst_valid", 64'(st_valid), 64'(0));
        chk("midrst_pkt", 64'(pkt_cnt), 64'(0));
        chk("midrst_beat", 64'(beat_cnt), 64'(0));

        // Alternate mode right after reset: tready 1,0,1,0...
        begin
            int idx;
            idx = 0;
            for (int i = 0; i < 16; i++) begin
                s_tdata  = DW'(idx + 1);
                s_tlast  = (idx == 7);
                s_tvalid = (idx < 8);
                #1;
                chk("alt_tready", 64'(s_tready), 64'((i % 2) == 0));
                if (s_tready && s_tvalid) idx++;
                @(negedge clk);
            end
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
        end
        chk("alt_beat", 64'(beat_cnt), 64'(8));
        expect_report("alt", 8, 36, 1'b0);

        // Hold mode blocks everything; mode change is combinational.
        bp_mode  = 2'd3;
        s_tvalid = 1'b1;
        s_tdata  = 16'h00AA;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_tready", 64'(s_tready), 64'(0));
            @(negedge clk);
        end
        chk("hold_beat", 64'(beat_cnt), 64'(8));
        s_tvalid = 1'b0;
        bp_mode  = 2'd0;
        #1;
        chk("mode_switch_tready", 64'(s_tready), 64'(1));

        // LFSR mode: throttled but data arrives intact.
        bp_mode = 2'd2;
        send_beat(16'd10, 1'b0);
        send_beat(16'd20, 1'b0);
        send_beat(16'd30, 1'b1);
        expect_report("lfsr", 3, 60, 1'b0);
        bp_mode = 2'd0;

        // Two-beat packet after the earlier reset.
        send_beat(16'd3, 1'b0);
        send_beat(16'd4, 1'b1);
        expect_report("two", 2, 7, 1'b0);
        chk("two_pkt", 64'(pkt_cnt), 64'(3));

        // Overlength: 2049 beats of 1 -> len saturates, err set, sum 2049.
        for (int i = 0; i < MAXLEN; i++) send_beat(16'd1, 1'b0);
        send_beat(16'd1, 1'b1);
        expect_report("ovf", MAXLEN, MAXLEN + 1, 1'b1);

        // Error and length cleared for the next packet.
        send_beat(16'd5, 1'b1);
        expect_report("after_ovf", 1, 5, 1'b0);
        chk("final_pkt", 64'(pkt_cnt), 64'(5));
        chk("final_beat", 64'(beat_cnt), 64'(2063));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
